writeback_arbiter: RTL and testbench

- Writer-side counterpart of the register file: owns the single write port (RegWrite/a3/wd3) and arbitrates results from the single-cycle ALU path and the multi-cycle memory path.
- Memory results are buffered in a small FIFO; ALU results have priority, bounded by a starvation limit.
- Holds a busy scoreboard of destination registers with outstanding memory results; decode uses it to stall on load-use hazards.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/writeback_arbiter.sv | 114 +++++++++++
 tb/tb_writeback_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for memory-path writeback results; DEPTH must be a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        pushEntry,
  input  logic             pop,
  output wb_entry_t        headEntry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign headEntry = mem[rdPtr];

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-file write port: ALU results win, memory results queue in a FIFO.
// Build option WB_BYPASS_EN lets a memory result skip the empty FIFO when the ALU is idle.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3,
  localparam int CNT_W     = $clog2(DEPTH) + 1,
  localparam int SW        = $clog2(STARVE_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [DATA_W-1:0]     wd3,
  output logic [NUM_REGS-1:0]   busy,
  output logic [CNT_W-1:0]      fifo_count
);

  wb_entry_t           headEntry;
  wb_entry_t           selEntry;
  wb_src_e             selSrc;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                fifoPush;
  logic                fifoPop;
  logic                forceMem;
  logic                bypass;
  logic [SW-1:0]       starveLeft;
  logic [NUM_REGS-1:0] busyNext;

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifoPush),
    .pushEntry ('{rd: mem_rd, data: mem_data}),
    .pop       (fifoPop),
    .headEntry (headEntry),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .count     (fifo_count)
  );

  // starveLeft counts down ALU wins still allowed before the FIFO head is forced out.
  always_comb begin
    forceMem = (starveLeft == '0) && !fifoEmpty;
`ifdef WB_BYPASS_EN
    bypass = fifoEmpty && !alu_valid && mem_valid;
`else
    bypass = 1'b0;
`endif
    selSrc   = SRC_NONE;
    selEntry = headEntry;
    fifoPop  = 1'b0;
    if (forceMem) begin
      selSrc  = SRC_MEM;
      fifoPop = 1'b1;
    end else if (alu_valid) begin
      selSrc   = SRC_ALU;
      selEntry = '{rd: alu_rd, data: alu_data};
    end else if (!fifoEmpty) begin
      selSrc  = SRC_MEM;
      fifoPop = 1'b1;
    end else if (bypass) begin
      selSrc   = SRC_MEM;
      selEntry = '{rd: mem_rd, data: mem_data};
    end
    alu_ready = !forceMem;
    mem_ready = !fifoFull;
    fifoPush  = mem_valid && !fifoFull && !bypass;
  end

  // A new issue to the same register outranks the clear from a completing load.
  always_comb begin
    busyNext = busy;
    if (selSrc == SRC_MEM) busyNext[selEntry.rd] = 1'b0;
    if (issue_valid)       busyNext[issue_rd]    = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      busy       <= '0;
      starveLeft <= SW'(STARVE_MAX);
    end else begin
      if (selSrc != SRC_NONE) begin
        a3       <= selEntry.rd;
        wd3      <= selEntry.data;
        RegWrite <= (selEntry.rd != '0);
      end else begin
        RegWrite <= 1'b0;
      end
      if (fifoEmpty || fifoPop)
        starveLeft <= SW'(STARVE_MAX);
      else if (selSrc == SRC_ALU && starveLeft != '0)
        starveLeft <= starveLeft - SW'(1);
      busy <= busyNext;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter (DEPTH=4, STARVE_MAX=3).
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        RegWrite;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad = 0;

  writeback_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RegWrite(RegWrite), .a3(a3), .wd3(wd3), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        iv;  logic [4:0] ird;
    logic        eAr; logic       eMr;
    logic        eRw; logic [4:0] eA3; logic [31:0] eWd; logic [31:0] eBusy; logic [2:0] eCnt;
  } vec_t;

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic iv, logic [4:0] ird, logic eAr, logic eMr,
                              logic eRw, logic [4:0] eA3, logic [31:0] eWd,
                              logic [31:0] eBusy, logic [2:0] eCnt);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.eAr = eAr; v.eMr = eMr; v.eRw = eRw; v.eA3 = eA3;
    v.eWd = eWd; v.eBusy = eBusy; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; handshakes checked at the falling edge,
  // registered outputs just after the next rising edge.
  task automatic step(string tag, vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
    issue_valid = v.iv; issue_rd = v.ird;
    @(negedge clk);
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(v.eAr));
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(v.eMr));
    @(posedge clk);
    #1;
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(v.eRw));
    chk({tag, ".a3"}, 32'(a3), 32'(v.eA3));
    chk({tag, ".wd3"}, wd3, v.eWd);
    chk({tag, ".busy"}, busy, v.eBusy);
    chk({tag, ".count"}, 32'(fifo_count), 32'(v.eCnt));
  endtask

  vec_t tbl[$];

  initial begin
    // Mem results only arrive with an empty FIFO while the ALU is also valid, so
    // the table holds with or without the bypass path.
    //              av ard  ad          mv mrd md          iv ird ar mr rw a3  wd          busy          cnt
    tbl.push_back(mk(1, 5,  32'h1234,   0, 0,  0,          0, 0,  1, 1, 1, 5,  32'h1234,   32'h0,        0));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 1, 0, 5,  32'h1234,   32'h0,        0));
    tbl.push_back(mk(1, 20, 32'h200,    1, 1,  32'hA1,     1, 1,  1, 1, 1, 20, 32'h200,    32'h2,        1));
    tbl.push_back(mk(1, 20, 32'h201,    1, 2,  32'hA2,     1, 2,  1, 1, 1, 20, 32'h201,    32'h6,        2));
    tbl.push_back(mk(1, 20, 32'h202,    1, 3,  32'hA3,     1, 3,  1, 1, 1, 20, 32'h202,    32'hE,        3));
    tbl.push_back(mk(1, 20, 32'h203,    1, 4,  32'hA4,     1, 4,  1, 1, 1, 20, 32'h203,    32'h1E,       4));
    tbl.push_back(mk(1, 20, 32'h204,    1, 5,  32'hA5,     0, 0,  0, 0, 1, 1,  32'hA1,     32'h1C,       3));
    tbl.push_back(mk(1, 20, 32'h205,    1, 5,  32'hA5,     0, 0,  1, 1, 1, 20, 32'h205,    32'h1C,       4));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 0, 1, 2,  32'hA2,     32'h18,       3));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 1, 1, 3,  32'hA3,     32'h10,       2));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 1, 1, 4,  32'hA4,     32'h0,        1));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 1, 1, 5,  32'hA5,     32'h0,        0));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 1, 0, 5,  32'hA5,     32'h0,        0));
    tbl.push_back(mk(1, 0,  32'hFFFF,   1, 0,  32'h77,     0, 0,  1, 1, 0, 0,  32'hFFFF,   32'h0,        1));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          0, 0,  1, 1, 0, 0,  32'h77,     32'h0,        0));
    tbl.push_back(mk(1, 7,  32'h70,     1, 12, 32'hC0,     1, 12, 1, 1, 1, 7,  32'h70,     32'h1000,     1));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          1, 12, 1, 1, 1, 12, 32'hC0,     32'h1000,     0));
    tbl.push_back(mk(0, 0,  0,          0, 0,  0,          1, 0,  1, 1, 0, 12, 32'hC0,     32'h1000,     0));

    #1 reset = 1'b1;
    #1;
    chk("rst.RegWrite", 32'(RegWrite), 32'h0);
    chk("rst.a3", 32'(a3), 32'h0);
    chk("rst.wd3", wd3, 32'h0);
    chk("rst.busy", busy, 32'h0);
    chk("rst.count", 32'(fifo_count), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst.alu_ready", 32'(alu_ready), 32'h1);
    chk("rst.mem_ready", 32'(mem_ready), 32'h1);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // Memory-only latency, rd=8.
    step("mem.issue", mk(0, 0, 0, 0, 0, 0, 1, 8, 1, 1, 0, 12, 32'hC0, 32'h1100, 0));
`ifdef WB_BYPASS_EN
    step("mem.push", mk(0, 0, 0, 1, 8, 32'hDEADBEEF, 0, 0, 1, 1, 1, 8, 32'hDEADBEEF, 32'h1000, 0));
    step("mem.after", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8, 32'hDEADBEEF, 32'h1000, 0));
`else
    step("mem.push", mk(0, 0, 0, 1, 8, 32'hDEADBEEF, 0, 0, 1, 1, 0, 12, 32'hC0, 32'h1100, 1));
    step("mem.pop", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 32'hDEADBEEF, 32'h1000, 0));
`endif

    // Three queued entries and busy=0x1100, then async reset between edges.
    step("fill1", mk(1, 1, 32'h11, 1, 9,  32'h90, 1, 8, 1, 1, 1, 1, 32'h11, 32'h1100, 1));
    step("fill2", mk(1, 1, 32'h12, 1, 10, 32'h91, 0, 0, 1, 1, 1, 1, 32'h12, 32'h1100, 2));
    step("fill3", mk(1, 1, 32'h13, 1, 11, 32'h92, 0, 0, 1, 1, 1, 1, 32'h13, 32'h1100, 3));
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst.RegWrite", 32'(RegWrite), 32'h0);
    chk("arst.a3", 32'(a3), 32'h0);
    chk("arst.wd3", wd3, 32'h0);
    chk("arst.busy", busy, 32'h0);
    chk("arst.count", 32'(fifo_count), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
`ifdef WB_BYPASS_EN
    step("post.push", mk(0, 0, 0, 1, 9, 32'h99, 0, 0, 1, 1, 1, 9, 32'h99, 32'h0, 0));
    step("post.after", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 9, 32'h99, 32'h0, 0));
`else
    step("post.push", mk(0, 0, 0, 1, 9, 32'h99, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 1));
    step("post.pop", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 32'h99, 32'h0, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
